// File: rtl/button_event_capture.sv
// button_event_capture: synchronises and debounces active-low push-buttons, latches presses and
// exposes LEVEL/STATUS/MASK/EDGE over Avalon-MM (read latency 1). BTN_AUTOREPEAT_EN adds hold-to-repeat.
module button_event_capture #(
    parameter int NUM_BTN         = 4,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = 20,
    parameter int REPEAT_DELAY    = 25000000,
    parameter int REPEAT_PERIOD   = 10000000
) (
    input  logic               clk,
    input  logic               RST,
    input  logic [NUM_BTN-1:0] btn_raw,
    input  logic [1:0]         avs_address,
    input  logic               avs_read,
    input  logic               avs_write,
    input  logic [31:0]        avs_writedata,
    output logic [31:0]        avs_readdata,
    output logic               irq,
    output logic [NUM_BTN-1:0] btn_level
);
    localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [NUM_BTN-1:0] sync1_q, sync2_q, sync_n;
    logic [NUM_BTN-1:0] stable_q, stable_d;
    logic [CNT_W-1:0]   deb_q [NUM_BTN];
    logic [CNT_W-1:0]   deb_d [NUM_BTN];
    logic [NUM_BTN-1:0] rpt_evt, press;
    logic [NUM_BTN-1:0] edge_q, edge_d, mask_q, mask_d, wr_bits;
    logic [7:0]         count_q, count_d;
    logic [8:0]         count_sum;
    logic               irq_q, wr_status, wr_mask, wr_edge;
    logic [31:0]        rdata_q, rdata_d;
    wire                unused_wdata;

    assign sync_n       = ~sync2_q;
    assign wr_bits      = avs_writedata[NUM_BTN-1:0];
    assign unused_wdata = &{1'b0, avs_writedata[31:NUM_BTN]};

    // A counter only runs while the synchronised input disagrees with the accepted state.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            stable_d[i] = stable_q[i];
            deb_d[i]    = '0;
            if (sync_n[i] != stable_q[i]) begin
                if (deb_q[i] == DEB_LAST) begin
                    stable_d[i] = sync_n[i];
                end else begin
                    deb_d[i] = deb_q[i] + CNT_W'(1);
                end
            end
        end
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] REP_FIRST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] REP_NEXT  = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0]   rep_q [NUM_BTN];
    logic [CNT_W-1:0]   rep_d [NUM_BTN];
    logic [NUM_BTN-1:0] armed_q, armed_d;

    // armed marks that the first (long) delay has elapsed; later repeats use the short period.
    always_comb begin
        for (int i = 0; i < NUM_BTN; i++) begin
            rep_d[i]   = '0;
            armed_d[i] = 1'b0;
            rpt_evt[i] = 1'b0;
            if (stable_q[i]) begin
                if (rep_q[i] == (armed_q[i] ? REP_NEXT : REP_FIRST)) begin
                    rpt_evt[i] = 1'b1;
                    armed_d[i] = 1'b1;
                end else begin
                    rep_d[i]   = rep_q[i] + CNT_W'(1);
                    armed_d[i] = armed_q[i];
                end
            end
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            armed_q <= '0;
            for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= '0;
        end else begin
            armed_q <= armed_d;
            for (int i = 0; i < NUM_BTN; i++) rep_q[i] <= rep_d[i];
        end
    end
`else
    localparam int unused_repeat_cfg = REPEAT_DELAY + REPEAT_PERIOD;
    assign rpt_evt = '0;
`endif

    assign press     = (stable_d & ~stable_q) | rpt_evt;
    assign wr_status = avs_write && (avs_address == 2'd1);
    assign wr_mask   = avs_write && (avs_address == 2'd2);
    assign wr_edge   = avs_write && (avs_address == 2'd3);

    // A press in the same cycle as a clear wins over the clear (EDGE set, count restarts from it).
    always_comb begin
        mask_d    = wr_mask ? wr_bits : mask_q;
        edge_d    = (wr_edge ? (edge_q & ~wr_bits) : edge_q) | press;
        count_sum = wr_status ? 9'd0 : {1'b0, count_q};
        for (int i = 0; i < NUM_BTN; i++) count_sum = count_sum + 9'(press[i]);
        count_d   = (count_sum > 9'd255) ? 8'hFF : count_sum[7:0];
        rdata_d   = rdata_q;
        if (avs_read) begin
            case (avs_address)
                2'd0:    rdata_d = 32'(stable_q);
                2'd1:    rdata_d = {16'd0, count_q, 7'd0, irq_q};
                2'd2:    rdata_d = 32'(mask_q);
                default: rdata_d = 32'(edge_q);
            endcase
        end
    end

    always_ff @(posedge clk or negedge RST) begin
        if (!RST) begin
            sync1_q  <= '1;
            sync2_q  <= '1;
            stable_q <= '0;
            edge_q   <= '0;
            mask_q   <= '0;
            count_q  <= '0;
            irq_q    <= 1'b0;
            rdata_q  <= '0;
            for (int i = 0; i < NUM_BTN; i++) deb_q[i] <= '0;
        end else begin
            sync1_q  <= btn_raw;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            edge_q   <= edge_d;
            mask_q   <= mask_d;
            count_q  <= count_d;
            irq_q    <= |(edge_q & mask_q);
            rdata_q  <= rdata_d;
            for (int i = 0; i < NUM_BTN; i++) deb_q[i] <= deb_d[i];
        end
    end

    assign avs_readdata = rdata_q;
    assign irq          = irq_q;
    assign btn_level    = stable_q;
endmodule
